pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Front-end sequencing controller for the pipelined MIPS core. It drives the `pc` register's `nPC` and `En` inputs, the IF/ID enable, and the ID/EX bubble. Every cycle it picks the next fetch address from sequential flow or a D-stage redirect, and it merges load-use stalls from the hazard unit with a mult/div busy tracker it owns. It sits between the hazard unit, the D-stage branch/jump comparator, and the `pc` register.

## Interface
Parameters:
- RESET_PC, 32'h00003000, fetch address after reset
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- PC_F  in  32  current PC (the `pc` register output)
- stall_hz  in  1  load-use/data hazard stall request from the hazard unit
- redirect_D  in  1  D-stage instruction is a taken branch, j, jal, jr or jalr
- target_D  in  32  redirect target, valid when redirect_D=1
- md_start_E  in  1  E-stage holds mult/multu/div/divu (a valid, non-bubble instruction)
- md_div_E  in  1  1 = div/divu, 0 = mult/multu; qualified by md_start_E
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- nPC  out  32  next PC to the `pc` register
- En_PC  out  1  `pc` register write enable
- En_D  out  1  IF/ID register write enable
- flush_E  out  1  clear ID/EX, inserting a bubble
- md_busy  out  1  mult/div unit is busy (registered state)

## Operation
- State machine: IDLE and MD_BUSY. There is a 4-bit down-counter `cnt`.
- IDLE:
  - If md_start_E=1, the next state is MD_BUSY and cnt <= md_div_E ? DIV_CYCLES : MULT_CYCLES.
- MD_BUSY:
  - Each cycle cnt decrements.
  - When cnt==1 at a clock edge, the next state is IDLE and cnt <= 0.
  - If md_start_E=1 while in MD_BUSY, cnt reloads per md_div_E and the state stays MD_BUSY. Defensive only: this cannot occur legally.
- md_busy = (state==MD_BUSY).
- md_stall = md_use_D & (md_start_E | md_busy).
- stall = stall_hz | md_stall.
- nPC = redirect_D ? target_D : PC_F + 4. Addition is 32-bit, modulo 2^32, with wrap from 32'hFFFFFFFC to 0 and no flag.
- The delay slot is architectural. The instruction in F when a redirect is seen in D is never killed.
- stall=1: En_PC=0, En_D=0, flush_E=1. nPC is still driven as above but not written.
- stall=0: En_PC=1, En_D=1, flush_E=0.
- Redirect during a stall is not latched. The branch stays in D and re-asserts redirect_D in the first unstalled cycle.
- A stall does not suppress md_start_E. The instruction already in E proceeds.

## Timing
- nPC, En_PC, En_D and flush_E are combinational from inputs and the registered state: same-cycle response, zero latency.
- A mult started in cycle t makes md_busy=1 in cycles t+1 through t+MULT_CYCLES, and 0 from t+MULT_CYCLES+1. The same holds for div with DIV_CYCLES.
- A D-stage HI/LO user is stalled in cycle t (via md_start_E) and in cycles t+1..t+N. It advances in cycle t+N+1.
- Reset (sampled at an edge):
  - Next state is IDLE, cnt=0, md_busy=0.
  - While reset=1 the outputs are forced to nPC=RESET_PC, En_PC=1, En_D=1, flush_E=1.
  - Reset mid-busy aborts the count immediately.
- Simultaneous stall_hz and md_stall give a single stall with identical outputs.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the RESET_PC default
  - the MULT_CYCLES and DIV_CYCLES defaults
  - the state encoding (IDLE=0, MD_BUSY=1)
- One sub-module, `md_busy_counter`: the FSM plus cnt, with inputs start/is_div and output busy.
- The parent holds the nPC mux, the adder and the stall merge.

## Test plan
- Reset with PC_F=X: nPC=32'h00003000, En_PC=1, flush_E=1. After release with no inputs and PC_F=32'h00003000: nPC=32'h00003004, En_PC=1.
- redirect_D=1, target_D=32'h00003100, PC_F=32'h0000300C: nPC=32'h00003100, En_PC=1, En_D=1, flush_E=0.
- md_start_E=1, md_div_E=0 at cycle 0, md_use_D=1 held: stall asserted cycles 0–5, released cycle 6; md_busy high cycles 1–5.
- div start at cycle 0, mfhi in D from cycle 3: stall cycles 3–10; md_busy falls at cycle 11.
- stall_hz=1 with redirect_D=1, target_D=32'h00003200: En_PC=0, En_D=0, flush_E=1. Next cycle with stall_hz=0 and redirect still high: En_PC=1, nPC=32'h00003200.
- reset asserted in cycle 4 of a div busy period: md_busy=0 the following cycle; md_use_D=1 then causes no stall.
- PC_F=32'hFFFFFFFC, no redirect: nPC=32'h00000000.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared defaults and state encoding for the pc sequencer
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'h00003000;
  localparam int          MULT_CYCLES_DEF = 5;
  localparam int          DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pc_sequencer_md_busy_counter.sv
// rtl/pc_sequencer_md_busy_counter.sv - mult/div busy tracker with a 4-bit down-counter
module md_busy_counter
  import pc_seq_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Next-state: a start (re)loads the count; the last busy cycle is the one with cnt==1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (start) begin
          // Cannot happen with a legal instruction stream; reload rather than lose track
          state_d = MD_BUSY;
          cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // State and count registers; reset aborts any count in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC select and front-end stall/bubble control
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = pc_seq_pkg::RESET_PC_DEF,
  parameter int          MULT_CYCLES = pc_seq_pkg::MULT_CYCLES_DEF,
  parameter int          DIV_CYCLES  = pc_seq_pkg::DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_F,
  input  logic        stall_hz,
  input  logic        redirect_D,
  input  logic [31:0] target_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        md_use_D,
  output logic [31:0] nPC,
  output logic        En_PC,
  output logic        En_D,
  output logic        flush_E,
  output logic        md_busy
);

  logic        md_stall;
  logic        stall;
  logic [31:0] seq_pc;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_E),
    .is_div (md_div_E),
    .busy   (md_busy)
  );

  // A HI/LO user in D waits both for an op entering E this cycle and for one still running
  assign md_stall = md_use_D & (md_start_E | md_busy);
  assign stall    = stall_hz | md_stall;
  assign seq_pc   = PC_F + 32'd4;

  // Next-PC mux and enables; the delay slot is never killed, so a redirect only steers nPC
  always_comb begin
    nPC     = redirect_D ? target_D : seq_pc;
    En_PC   = ~stall;
    En_D    = ~stall;
    flush_E = stall;
    if (reset) begin
      nPC     = RESET_PC;
      En_PC   = 1'b1;
      En_D    = 1'b1;
      flush_E = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] PC_F;
  logic        stall_hz;
  logic        redirect_D;
  logic [31:0] target_D;
  logic        md_start_E;
  logic        md_div_E;
  logic        md_use_D;
  logic [31:0] nPC;
  logic        En_PC;
  logic        En_D;
  logic        flush_E;
  logic        md_busy;

  int total;
  int bad;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .PC_F       (PC_F),
    .stall_hz   (stall_hz),
    .redirect_D (redirect_D),
    .target_D   (target_D),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_use_D   (md_use_D),
    .nPC        (nPC),
    .En_PC      (En_PC),
    .En_D       (En_D),
    .flush_E    (flush_E),
    .md_busy    (md_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_hz   = 1'b0;
    redirect_D = 1'b0;
    target_D   = 32'h0;
    md_start_E = 1'b0;
    md_div_E   = 1'b0;
    md_use_D   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PC_F  = 'x;
    clear_inputs();
    next_cycle();
    total++; if (nPC !== 32'h00003000) begin bad++; $display("FAIL reset_npc: got %h want %h", nPC, 32'h00003000); end
    total++; if (En_PC !== 1'b1) begin bad++; $display("FAIL reset_en_pc: got %b want 1", En_PC); end
    total++; if (En_D !== 1'b1) begin bad++; $display("FAIL reset_en_d: got %b want 1", En_D); end
    total++; if (flush_E !== 1'b1) begin bad++; $display("FAIL reset_flush: got %b want 1", flush_E); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    reset = 1'b0;
    PC_F  = 32'h00003000;
    #1;
    total++; if (nPC !== 32'h00003004) begin bad++; $display("FAIL post_reset_npc: got %h want %h", nPC, 32'h00003004); end
    total++; if (En_PC !== 1'b1) begin bad++; $display("FAIL post_reset_en_pc: got %b want 1", En_PC); end
    total++; if (flush_E !== 1'b0) begin bad++; $display("FAIL post_reset_flush: got %b want 0", flush_E); end
    next_cycle();
  endtask

  task automatic test_redirect();
    redirect_D = 1'b1;
    target_D   = 32'h00003100;
    PC_F       = 32'h0000300C;
    #1;
    total++; if (nPC !== 32'h00003100) begin bad++; $display("FAIL redirect_npc: got %h want %h", nPC, 32'h00003100); end
    total++; if (En_PC !== 1'b1) begin bad++; $display("FAIL redirect_en_pc: got %b want 1", En_PC); end
    total++; if (En_D !== 1'b1) begin bad++; $display("FAIL redirect_en_d: got %b want 1", En_D); end
    total++; if (flush_E !== 1'b0) begin bad++; $display("FAIL redirect_flush: got %b want 0", flush_E); end
    next_cycle();
    clear_inputs();
    PC_F = 32'h00003100;
    #1;
    total++; if (nPC !== 32'h00003104) begin bad++; $display("FAIL seq_npc: got %h want %h", nPC, 32'h00003104); end
    next_cycle();
  endtask

  task automatic test_mult_stall();
    md_start_E = 1'b1;
    md_div_E   = 1'b0;
    md_use_D   = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      logic exp_stall;
      logic exp_busy;
      if (c == 1) md_start_E = 1'b0;
      #1;
      exp_stall = (c <= 5);
      exp_busy  = (c >= 1) && (c <= 5);
      total++; if (En_PC !== ~exp_stall) begin bad++; $display("FAIL mult_en_pc c=%0d: got %b want %b", c, En_PC, ~exp_stall); end
      total++; if (En_D !== ~exp_stall) begin bad++; $display("FAIL mult_en_d c=%0d: got %b want %b", c, En_D, ~exp_stall); end
      total++; if (flush_E !== exp_stall) begin bad++; $display("FAIL mult_flush c=%0d: got %b want %b", c, flush_E, exp_stall); end
      total++; if (md_busy !== exp_busy) begin bad++; $display("FAIL mult_busy c=%0d: got %b want %b", c, md_busy, exp_busy); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_div_stall();
    md_start_E = 1'b1;
    md_div_E   = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      logic exp_stall;
      logic exp_busy;
      if (c == 1) md_start_E = 1'b0;
      md_use_D = (c >= 3);
      #1;
      exp_stall = (c >= 3) && (c <= 10);
      exp_busy  = (c >= 1) && (c <= 10);
      total++; if (En_PC !== ~exp_stall) begin bad++; $display("FAIL div_en_pc c=%0d: got %b want %b", c, En_PC, ~exp_stall); end
      total++; if (flush_E !== exp_stall) begin bad++; $display("FAIL div_flush c=%0d: got %b want %b", c, flush_E, exp_stall); end
      total++; if (md_busy !== exp_busy) begin bad++; $display("FAIL div_busy c=%0d: got %b want %b", c, md_busy, exp_busy); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_stall_redirect();
    PC_F       = 32'h00003010;
    stall_hz   = 1'b1;
    redirect_D = 1'b1;
    target_D   = 32'h00003200;
    #1;
    total++; if (En_PC !== 1'b0) begin bad++; $display("FAIL hz_en_pc: got %b want 0", En_PC); end
    total++; if (En_D !== 1'b0) begin bad++; $display("FAIL hz_en_d: got %b want 0", En_D); end
    total++; if (flush_E !== 1'b1) begin bad++; $display("FAIL hz_flush: got %b want 1", flush_E); end
    total++; if (nPC !== 32'h00003200) begin bad++; $display("FAIL hz_npc: got %h want %h", nPC, 32'h00003200); end
    next_cycle();
    stall_hz = 1'b0;
    #1;
    total++; if (En_PC !== 1'b1) begin bad++; $display("FAIL unstall_en_pc: got %b want 1", En_PC); end
    total++; if (flush_E !== 1'b0) begin bad++; $display("FAIL unstall_flush: got %b want 0", flush_E); end
    total++; if (nPC !== 32'h00003200) begin bad++; $display("FAIL unstall_npc: got %h want %h", nPC, 32'h00003200); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_double_stall();
    stall_hz   = 1'b1;
    md_start_E = 1'b1;
    md_div_E   = 1'b0;
    md_use_D   = 1'b1;
    #1;
    total++; if (En_PC !== 1'b0) begin bad++; $display("FAIL dbl_en_pc: got %b want 0", En_PC); end
    total++; if (En_D !== 1'b0) begin bad++; $display("FAIL dbl_en_d: got %b want 0", En_D); end
    total++; if (flush_E !== 1'b1) begin bad++; $display("FAIL dbl_flush: got %b want 1", flush_E); end
    next_cycle();
    clear_inputs();
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL dbl_start_busy: got %b want 1", md_busy); end
    for (int c = 0; c < 5; c++) next_cycle();
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL dbl_done_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_reset_abort();
    PC_F       = 32'h00003040;
    md_start_E = 1'b1;
    md_div_E   = 1'b1;
    next_cycle();
    md_start_E = 1'b0;
    for (int c = 1; c <= 3; c++) next_cycle();
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", md_busy); end
    reset    = 1'b1;
    md_use_D = 1'b1;
    #1;
    total++; if (nPC !== 32'h00003000) begin bad++; $display("FAIL abort_rst_npc: got %h want %h", nPC, 32'h00003000); end
    total++; if (En_PC !== 1'b1) begin bad++; $display("FAIL abort_rst_en_pc: got %b want 1", En_PC); end
    total++; if (flush_E !== 1'b1) begin bad++; $display("FAIL abort_rst_flush: got %b want 1", flush_E); end
    next_cycle();
    reset = 1'b0;
    #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", md_busy); end
    total++; if (En_PC !== 1'b1) begin bad++; $display("FAIL abort_en_pc: got %b want 1", En_PC); end
    total++; if (flush_E !== 1'b0) begin bad++; $display("FAIL abort_flush: got %b want 0", flush_E); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_wrap();
    PC_F = 32'hFFFFFFFC;
    #1;
    total++; if (nPC !== 32'h00000000) begin bad++; $display("FAIL wrap_npc: got %h want %h", nPC, 32'h00000000); end
    PC_F = 32'h7FFFFFFC;
    #1;
    total++; if (nPC !== 32'h80000000) begin bad++; $display("FAIL carry_npc: got %h want %h", nPC, 32'h80000000); end
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    PC_F  = 'x;
    clear_inputs();
    test_reset();
    test_redirect();
    test_mult_stall();
    test_div_stall();
    test_stall_redirect();
    test_double_stall();
    test_reset_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
